// File: rtl/omsp_mem_pkg.sv
// Shared constants and helpers for the omsp_mem_model single-port memory.
package omsp_mem_pkg;

  localparam int CNT_W      = 32;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  function automatic int lane_cnt(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/omsp_mem_if.sv
// Memory access bus: request side driven by the master, results and status by the slave.
interface omsp_mem_if
  import omsp_mem_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 16
) ();

  localparam int NB = lane_cnt(DW);

  logic             cen;
  logic [NB-1:0]    wen;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    din;
  logic [DW-1:0]    dout;
  logic             dout_vld;
  logic             err;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;

  modport master (
    output cen, wen, addr, din,
    input  dout, dout_vld, err, rd_cnt, wr_cnt
  );

  modport slave (
    input  cen, wen, addr, din,
    output dout, dout_vld, err, rd_cnt, wr_cnt
  );

endinterface

// File: rtl/omsp_mem_rdpipe.sv
// RD_LAT-deep valid/data shift register; a stage only reloads when fed a valid entry,
// so the last stage holds the previous result during bubbles. reset_n=0 flushes it.
module omsp_mem_rdpipe #(
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          mclk,
  input  logic          reset_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data
);

  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]     data_q [RD_LAT];
  logic [DW-1:0]     data_d [RD_LAT];

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_vld;
    data_d[0] = in_vld ? in_data : data_q[0];
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[RD_LAT-1];
  assign out_data = data_q[RD_LAT-1];

endmodule

// File: rtl/omsp_mem_model.sv
// Single-port byte-lane memory with fixed read latency, sticky range error and
// optional access statistics (enabled by defining OMSP_MEM_STATS_EN).
module omsp_mem_model
  import omsp_mem_pkg::*;
#(
  parameter int AW     = 10,
  parameter int DW     = 16,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic        mclk,
  input  logic        reset_n,
  omsp_mem_if.slave   bus
);

  localparam int          NB      = lane_cnt(DW);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
    $error("omsp_mem_model: DW must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (2**AW)) begin : g_bad_depth
    $error("omsp_mem_model: DEPTH must be within 1..2**AW");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("omsp_mem_model: RD_LAT must be within 1..4");
  end

  logic [DW-1:0] mem_q [DEPTH];

  logic          acc;
  logic          rd_acc;
  logic          wr_acc;
  logic          in_range;
  logic [DW-1:0] rd_data;
  logic          err_q, err_d;
  logic          pipe_vld;
  logic [DW-1:0] pipe_data;

  always_comb begin
    acc      = reset_n & ~bus.cen;
    rd_acc   = acc & (&bus.wen);
    wr_acc   = acc & ~(&bus.wen);
    in_range = ({1'b0, bus.addr} < DEPTH_W);
    rd_data  = '0;
    if (rd_acc && in_range) rd_data = mem_q[bus.addr];
    err_d    = err_q | (acc & ~in_range);
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge mclk) begin
    if (wr_acc && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (!bus.wen[b]) mem_q[bus.addr][b*8 +: 8] <= bus.din[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  omsp_mem_rdpipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .in_vld   (rd_acc),
    .in_data  (rd_data),
    .out_vld  (pipe_vld),
    .out_data (pipe_data)
  );

  assign bus.dout     = pipe_data;
  assign bus.dout_vld = pipe_vld;
  assign bus.err      = err_q;

`ifdef OMSP_MEM_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (pipe_vld && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
    if (wr_acc   && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
  end

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign bus.rd_cnt = rd_cnt_q;
  assign bus.wr_cnt = wr_cnt_q;
`else
  assign bus.rd_cnt = '0;
  assign bus.wr_cnt = '0;
`endif

endmodule
